// File: rtl/cdnsdru_usb4_mb_coef_pkg.sv
// Shared widths, FSM state type and timeout default for the message-bus coefficient arbiter.
package cdnsdru_usb4_mb_coef_pkg;

  localparam int COEF_W              = 24;
  localparam int LEGACY_W            = 18;
  localparam int TIMEOUT_CYC_DEFAULT = 255;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/cdnsdru_usb4_mb_rr_arb.sv
// Combinational round-robin pick: first requesting lane at or above rr_ptr, wrapping.
module cdnsdru_usb4_mb_rr_arb #(
  parameter int  NUM_LANES = 4,
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [LANE_W-1:0]    rr_ptr,
  output logic [NUM_LANES-1:0] grant,
  output logic [LANE_W-1:0]    grant_idx
);

  always_comb begin
    logic             found;
    logic [LANE_W-1:0] lane;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    lane      = '0;
    for (int off = 0; off < NUM_LANES; off++) begin
      lane = LANE_W'((int'(rr_ptr) + off) % NUM_LANES);
      if (!found && req[lane]) begin
        found       = 1'b1;
        grant[lane] = 1'b1;
        grant_idx   = lane;
      end
    end
  end

endmodule

// File: rtl/cdnsdru_usb4_message_bus_pcs_coef_arb.sv
// Per-lane TX coefficient shadows arbitrated round-robin onto a single message-bus write port.
// Optional ack timeout enabled by CDNSDRU_USB4_MB_COEF_TIMEOUT_EN.
module cdnsdru_usb4_message_bus_pcs_coef_arb
  import cdnsdru_usb4_mb_coef_pkg::*;
#(
  parameter int  NUM_LANES   = 4,
  parameter int  TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
  localparam int LANE_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                          pipe_phy2mac_clk,
  input  logic                          pipe_phy2mac_rst,
  input  logic [NUM_LANES-1:0]          tx_coef_valid,
  input  logic [NUM_LANES*LEGACY_W-1:0] tx_preset_coef_legacy,
  input  logic [NUM_LANES*COEF_W-1:0]   tx_preset_coef_g67,
  input  logic [NUM_LANES-1:0]          g67rate,
  output logic [NUM_LANES*COEF_W-1:0]   tx_preset_coef_reg,
  output logic [NUM_LANES-1:0]          coef_pending,
  output logic [NUM_LANES-1:0]          coef_overrun,
  input  logic [NUM_LANES-1:0]          overrun_clr,
  output logic                          mb_req,
  output logic [LANE_W-1:0]             mb_lane,
  output logic [COEF_W-1:0]             mb_coef,
  input  logic                          mb_ack,
  output logic                          mb_timeout
);

  arb_state_e           state_q, state_d;
  logic [COEF_W-1:0]    shadow_q [NUM_LANES];
  logic [COEF_W-1:0]    shadow_d [NUM_LANES];
  logic [NUM_LANES-1:0] pending_q, pending_d;
  logic [NUM_LANES-1:0] overrun_q, overrun_d;
  logic [LANE_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [LANE_W-1:0]    mb_lane_q, mb_lane_d;
  logic [COEF_W-1:0]    mb_coef_q, mb_coef_d;
  logic [NUM_LANES-1:0] grant, sel_mask;
  logic [LANE_W-1:0]    grant_idx;
  logic                 pick, req_done, timeout_hit;

  cdnsdru_usb4_mb_rr_arb #(.NUM_LANES(NUM_LANES)) u_rr_arb (
    .req       (pending_q),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge pipe_phy2mac_clk or posedge pipe_phy2mac_rst) begin
    if (pipe_phy2mac_rst) state_q <= ST_IDLE;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pick     = 1'b0;
    req_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          pick    = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mb_ack || timeout_hit) begin
          req_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mb_req = (state_q == ST_REQ);
  end

  // A lane selected this cycle is exempt from overrun: its old value is already on the bus.
  always_comb begin
    sel_mask  = pick ? grant : '0;
    pending_d = (pending_q & ~sel_mask) | tx_coef_valid;
    overrun_d = (overrun_q & ~overrun_clr) | (tx_coef_valid & pending_q & ~sel_mask);
    mb_lane_d = pick ? grant_idx : mb_lane_q;
    mb_coef_d = pick ? shadow_q[grant_idx] : mb_coef_q;
    rr_ptr_d  = rr_ptr_q;
    if (req_done) begin
      rr_ptr_d = (mb_lane_q == LANE_W'(NUM_LANES - 1)) ? '0 : mb_lane_q + LANE_W'(1);
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      shadow_d[i] = shadow_q[i];
      if (tx_coef_valid[i]) begin
        shadow_d[i] = g67rate[i] ? tx_preset_coef_g67[i*COEF_W +: COEF_W]
                                 : {{(COEF_W-LEGACY_W){1'b0}}, tx_preset_coef_legacy[i*LEGACY_W +: LEGACY_W]};
      end
    end
  end

  always_ff @(posedge pipe_phy2mac_clk or posedge pipe_phy2mac_rst) begin
    if (pipe_phy2mac_rst) begin
      pending_q <= '0;
      overrun_q <= '0;
      rr_ptr_q  <= '0;
      mb_lane_q <= '0;
      mb_coef_q <= '0;
      for (int i = 0; i < NUM_LANES; i++) shadow_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      rr_ptr_q  <= rr_ptr_d;
      mb_lane_q <= mb_lane_d;
      mb_coef_q <= mb_coef_d;
      for (int i = 0; i < NUM_LANES; i++) shadow_q[i] <= shadow_d[i];
    end
  end

`ifdef CDNSDRU_USB4_MB_COEF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             mb_timeout_q;

  // Counter restarts at each REQ entry; the abandoned lane is not re-pended.
  assign timeout_hit = (state_q == ST_REQ) && !mb_ack && (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (pick)                     tmo_cnt_d = '0;
    else if (state_q == ST_REQ)   tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge pipe_phy2mac_clk or posedge pipe_phy2mac_rst) begin
    if (pipe_phy2mac_rst) begin
      tmo_cnt_q    <= '0;
      mb_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q    <= tmo_cnt_d;
      mb_timeout_q <= timeout_hit;
    end
  end

  assign mb_timeout = mb_timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign mb_timeout  = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) tx_preset_coef_reg[i*COEF_W +: COEF_W] = shadow_q[i];
  end

  assign coef_pending = pending_q;
  assign coef_overrun = overrun_q;
  assign mb_lane      = mb_lane_q;
  assign mb_coef      = mb_coef_q;

endmodule

// File: tb/tb_cdnsdru_usb4_message_bus_pcs_coef_arb.sv
// Directed bench for the message-bus coefficient arbiter (4 lanes).
module tb_cdnsdru_usb4_message_bus_pcs_coef_arb;

`ifdef CDNSDRU_USB4_MB_COEF_TIMEOUT_EN
  localparam int TB_TMO = 8;
`else
  localparam int TB_TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  tx_coef_valid = '0;
  logic [71:0] legacy = '0;
  logic [95:0] g67 = '0;
  logic [3:0]  g67rate = '0;
  logic [95:0] coef_reg;
  logic [3:0]  coef_pending, coef_overrun;
  logic [3:0]  overrun_clr = '0;
  logic        mb_req, mb_ack = 1'b0, mb_timeout;
  logic [1:0]  mb_lane;
  logic [23:0] mb_coef;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cdnsdru_usb4_message_bus_pcs_coef_arb #(.NUM_LANES(4), .TIMEOUT_CYC(TB_TMO)) dut (
    .pipe_phy2mac_clk      (clk),
    .pipe_phy2mac_rst      (rst),
    .tx_coef_valid         (tx_coef_valid),
    .tx_preset_coef_legacy (legacy),
    .tx_preset_coef_g67    (g67),
    .g67rate               (g67rate),
    .tx_preset_coef_reg    (coef_reg),
    .coef_pending          (coef_pending),
    .coef_overrun          (coef_overrun),
    .overrun_clr           (overrun_clr),
    .mb_req                (mb_req),
    .mb_lane               (mb_lane),
    .mb_coef               (mb_coef),
    .mb_ack                (mb_ack),
    .mb_timeout            (mb_timeout)
  );

  function automatic logic [23:0] shadow(input int i);
    return coef_reg[i*24 +: 24];
  endfunction

  task automatic set_lane(input int i, input logic g, input logic [23:0] v);
    g67rate[i] = g;
    if (g) g67[i*24 +: 24] = v;
    else   legacy[i*18 +: 18] = v[17:0];
  endtask

  task automatic do_reset();
    tx_coef_valid = '0; overrun_clr = '0; mb_ack = 1'b0; g67rate = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (mb_req !== 1'b0) begin n_fail++; $display("FAIL reset_mb_req: got %b want 0", mb_req); end
    n_checks++; if (coef_pending !== 4'h0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", coef_pending); end
    n_checks++; if (coef_overrun !== 4'h0) begin n_fail++; $display("FAIL reset_overrun: got %h want 0", coef_overrun); end
    n_checks++; if (coef_reg !== 96'h0) begin n_fail++; $display("FAIL reset_shadow: got %h want 0", coef_reg); end
    n_checks++; if (mb_lane !== 2'd0 || mb_coef !== 24'h0) begin n_fail++; $display("FAIL reset_mb_data: got %0d/%h want 0/0", mb_lane, mb_coef); end
    n_checks++; if (mb_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", mb_timeout); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    set_lane(0, 1'b0, 24'h02A5A5);
    tx_coef_valid = 4'b0001;
    @(negedge clk); tx_coef_valid = '0;
    n_checks++; if (shadow(0) !== 24'h02A5A5) begin n_fail++; $display("FAIL single_shadow: got %h want 02a5a5", shadow(0)); end
    n_checks++; if (coef_pending !== 4'b0001) begin n_fail++; $display("FAIL single_pending: got %b want 0001", coef_pending); end
    n_checks++; if (mb_req !== 1'b0) begin n_fail++; $display("FAIL single_req_early: got %b want 0", mb_req); end
    @(negedge clk);
    n_checks++; if (mb_req !== 1'b1 || mb_lane !== 2'd0 || mb_coef !== 24'h02A5A5)
      begin n_fail++; $display("FAIL single_req: got %b/%0d/%h want 1/0/02a5a5", mb_req, mb_lane, mb_coef); end
    n_checks++; if (coef_pending !== 4'b0000) begin n_fail++; $display("FAIL single_pend_clr: got %b want 0000", coef_pending); end
    mb_ack = 1'b1;
    @(negedge clk); mb_ack = 1'b0;
    n_checks++; if (mb_req !== 1'b0) begin n_fail++; $display("FAIL single_ack: got %b want 0", mb_req); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_p;
    do_reset();
    for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 24'hC0FFE0 + 24'(i));
    tx_coef_valid = 4'hF;
    @(negedge clk); tx_coef_valid = '0;
    n_checks++; if (coef_pending !== 4'hF) begin n_fail++; $display("FAIL rr_pending: got %h want f", coef_pending); end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      exp_p = 4'hF << (k + 1);
      n_checks++; if (mb_req !== 1'b1 || mb_lane !== 2'(k) || mb_coef !== 24'hC0FFE0 + 24'(k))
        begin n_fail++; $display("FAIL rr_issue%0d: got %b/%0d/%h want 1/%0d/%h", k, mb_req, mb_lane, mb_coef, k, 24'hC0FFE0 + 24'(k)); end
      n_checks++; if (coef_pending !== exp_p) begin n_fail++; $display("FAIL rr_pend%0d: got %b want %b", k, coef_pending, exp_p); end
      @(negedge clk);
      n_checks++; if (mb_req !== 1'b1 || mb_lane !== 2'(k)) begin n_fail++; $display("FAIL rr_hold%0d: got %b/%0d want 1/%0d", k, mb_req, mb_lane, k); end
      @(negedge clk);
      mb_ack = 1'b1;
      @(negedge clk); mb_ack = 1'b0;
      n_checks++; if (mb_req !== 1'b0) begin n_fail++; $display("FAIL rr_bubble%0d: got %b want 0", k, mb_req); end
      @(negedge clk);
    end
    n_checks++; if (mb_req !== 1'b0) begin n_fail++; $display("FAIL rr_done: got %b want 0", mb_req); end
  endtask

  task automatic test_overrun();
    do_reset();
    set_lane(1, 1'b0, 24'h000001);
    tx_coef_valid = 4'b0010;
    @(negedge clk); tx_coef_valid = '0;
    @(negedge clk);
    set_lane(2, 1'b1, 24'h111111); tx_coef_valid = 4'b0100;
    @(negedge clk);
    set_lane(2, 1'b1, 24'h222222);
    @(negedge clk); tx_coef_valid = '0;
    n_checks++; if (coef_overrun !== 4'b0100) begin n_fail++; $display("FAIL ovr_set: got %b want 0100", coef_overrun); end
    n_checks++; if (shadow(2) !== 24'h222222) begin n_fail++; $display("FAIL ovr_shadow: got %h want 222222", shadow(2)); end
    n_checks++; if (mb_req !== 1'b1 || mb_lane !== 2'd1) begin n_fail++; $display("FAIL ovr_l1_req: got %b/%0d want 1/1", mb_req, mb_lane); end
    mb_ack = 1'b1;
    @(negedge clk); mb_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (mb_req !== 1'b1 || mb_lane !== 2'd2 || mb_coef !== 24'h222222)
      begin n_fail++; $display("FAIL ovr_l2_req: got %b/%0d/%h want 1/2/222222", mb_req, mb_lane, mb_coef); end
    mb_ack = 1'b1;
    @(negedge clk); mb_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (mb_req !== 1'b0 || coef_pending !== 4'h0) begin n_fail++; $display("FAIL ovr_once: got %b/%b want 0/0000", mb_req, coef_pending); end
    overrun_clr = 4'b0100;
    @(negedge clk); overrun_clr = '0;
    n_checks++; if (coef_overrun !== 4'b0000) begin n_fail++; $display("FAIL ovr_clr: got %b want 0000", coef_overrun); end
  endtask

  task automatic test_clr_set_wins();
    do_reset();
    set_lane(1, 1'b0, 24'h000001); set_lane(3, 1'b1, 24'h333333);
    tx_coef_valid = 4'b1010;
    @(negedge clk);
    set_lane(3, 1'b1, 24'h444444); tx_coef_valid = 4'b1000; overrun_clr = 4'b1000;
    @(negedge clk); tx_coef_valid = '0; overrun_clr = '0;
    n_checks++; if (coef_overrun !== 4'b1000) begin n_fail++; $display("FAIL clr_set_wins: got %b want 1000", coef_overrun); end
  endtask

  task automatic test_ack_idle();
    do_reset();
    mb_ack = 1'b1;
    @(negedge clk); mb_ack = 1'b0;
    n_checks++; if (mb_req !== 1'b0) begin n_fail++; $display("FAIL idle_ack_req: got %b want 0", mb_req); end
    set_lane(0, 1'b1, 24'h0A0A0A); set_lane(1, 1'b1, 24'h0B0B0B);
    tx_coef_valid = 4'b0011;
    @(negedge clk); tx_coef_valid = '0;
    @(negedge clk);
    n_checks++; if (mb_lane !== 2'd0 || mb_coef !== 24'h0A0A0A) begin n_fail++; $display("FAIL idle_ack_ptr: got %0d/%h want 0/0a0a0a", mb_lane, mb_coef); end
  endtask

  task automatic test_select_collision();
    do_reset();
    set_lane(3, 1'b1, 24'h123456);
    tx_coef_valid = 4'b1000;
    @(negedge clk);
    set_lane(3, 1'b1, 24'hABCDEF);
    @(negedge clk); tx_coef_valid = '0;
    n_checks++; if (mb_req !== 1'b1 || mb_lane !== 2'd3 || mb_coef !== 24'h123456)
      begin n_fail++; $display("FAIL coll_req: got %b/%0d/%h want 1/3/123456", mb_req, mb_lane, mb_coef); end
    n_checks++; if (coef_pending !== 4'b1000 || coef_overrun !== 4'b0000)
      begin n_fail++; $display("FAIL coll_flags: got %b/%b want 1000/0000", coef_pending, coef_overrun); end
    mb_ack = 1'b1;
    @(negedge clk); mb_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (mb_req !== 1'b1 || mb_lane !== 2'd3 || mb_coef !== 24'hABCDEF)
      begin n_fail++; $display("FAIL coll_second: got %b/%0d/%h want 1/3/abcdef", mb_req, mb_lane, mb_coef); end
    mb_ack = 1'b1;
    @(negedge clk); mb_ack = 1'b0;
  endtask

  task automatic test_reset_mid_req();
    do_reset();
    set_lane(0, 1'b1, 24'h0F0F0F); set_lane(1, 1'b1, 24'h0E0E0E);
    tx_coef_valid = 4'b0011;
    @(negedge clk); tx_coef_valid = '0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (mb_req !== 1'b0 || coef_pending !== 4'h0 || coef_reg !== 96'h0)
      begin n_fail++; $display("FAIL rstmid_async: got %b/%b/%h want 0/0/0", mb_req, coef_pending, coef_reg); end
    n_checks++; if (mb_timeout !== 1'b0) begin n_fail++; $display("FAIL rstmid_timeout: got %b want 0", mb_timeout); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_checks++; if (mb_req !== 1'b0 || mb_timeout !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: got %b/%b want 0/0", mb_req, mb_timeout); end
  endtask

`ifdef CDNSDRU_USB4_MB_COEF_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    set_lane(0, 1'b1, 24'h00AAAA); set_lane(1, 1'b1, 24'h00BBBB);
    tx_coef_valid = 4'b0011;
    @(negedge clk); tx_coef_valid = '0;
    @(negedge clk);
    for (int c = 0; c < 8; c++) begin
      n_checks++; if (mb_req !== 1'b1 || mb_timeout !== 1'b0)
        begin n_fail++; $display("FAIL tmo_wait%0d: got %b/%b want 1/0", c, mb_req, mb_timeout); end
      @(negedge clk);
    end
    n_checks++; if (mb_req !== 1'b0 || mb_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_pulse: got %b/%b want 0/1", mb_req, mb_timeout); end
    @(negedge clk);
    n_checks++; if (mb_timeout !== 1'b0 || mb_req !== 1'b1 || mb_lane !== 2'd1 || mb_coef !== 24'h00BBBB)
      begin n_fail++; $display("FAIL tmo_next: got %b/%b/%0d/%h want 0/1/1/00bbbb", mb_timeout, mb_req, mb_lane, mb_coef); end
    n_checks++; if (coef_pending !== 4'h0) begin n_fail++; $display("FAIL tmo_nopend: got %b want 0000", coef_pending); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overrun();
    test_clr_set_wins();
    test_ack_idle();
    test_select_collision();
    test_reset_mid_req();
`ifdef CDNSDRU_USB4_MB_COEF_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
